// File: rtl/cbus_mem_responder.sv
// Cache-bus responder backed by a word-addressed, byte-strobed memory.
// Serves wrapping bursts with a programmable first-beat latency and optional bubbles.

package cbus_pkg;

  typedef logic [2:0] msize_t;

  typedef enum logic [3:0] {
    MLEN1, MLEN2, MLEN3, MLEN4, MLEN5, MLEN6, MLEN7, MLEN8,
    MLEN9, MLEN10, MLEN11, MLEN12, MLEN13, MLEN14, MLEN15, MLEN16
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_mem_responder
  import cbus_pkg::*;
#(
  parameter int ADDR_BITS    = 14,
  parameter int INIT_LATENCY = 2,
  parameter int STALL_EVERY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int WORDS     = 1 << WORD_BITS;
  localparam int STALL_N   = (STALL_EVERY > 0) ? STALL_EVERY : 1;
  localparam logic [15:0] LAT_LOAD   = 16'(INIT_LATENCY - 1);
  localparam logic [15:0] STALL_LAST = 16'(STALL_N - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t               state;
  logic [WORD_BITS-1:0] word_addr;
  logic [3:0]           len_q;
  logic                 wr_q;
  logic [3:0]           beat_cnt;
  logic [15:0]          lat_cnt;
  logic [15:0]          stall_cnt;
  logic                 ready_q;
  logic                 last_q;

  logic [31:0]          mem [WORDS];

  logic [WORD_BITS-1:0] len_mask;
  logic [WORD_BITS-1:0] next_addr;
  logic                 beat_write;
  logic [31:0]          rd_data;
  logic                 unused;

  // Only the low log2(len+1) bits advance; the upper bits pin the aligned block.
  assign len_mask  = WORD_BITS'(len_q);
  assign next_addr = (word_addr & ~len_mask) | ((word_addr + WORD_BITS'(1)) & len_mask);

  assign beat_write = ready_q && wr_q && creq.valid && !reset;
  assign rd_data    = (ready_q && !wr_q) ? mem[word_addr] : 32'h0;
  assign cresp      = '{ready: ready_q, last: last_q, data: rd_data};

  assign unused = ^{creq.size, creq.addr[31:ADDR_BITS], creq.addr[1:0]};

  always_ff @(posedge clk) begin
    if (beat_write) begin
      for (int i = 0; i < 4; i++) begin
        if (creq.strobe[i]) mem[word_addr][8*i +: 8] <= creq.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      last_q    <= 1'b0;
      beat_cnt  <= 4'd0;
      lat_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          last_q  <= 1'b0;
          if (creq.valid) begin
            word_addr <= creq.addr[ADDR_BITS-1:2];
            len_q     <= creq.len;
            wr_q      <= creq.is_write;
            lat_cnt   <= LAT_LOAD;
            beat_cnt  <= 4'd0;
            stall_cnt <= 16'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!creq.valid) begin
            state <= IDLE;
          end else if (lat_cnt == 16'd0) begin
            state   <= BURST;
            ready_q <= 1'b1;
            last_q  <= (len_q == 4'd0);
          end else begin
            lat_cnt <= lat_cnt - 16'd1;
          end
        end
        BURST: begin
          if (!creq.valid) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (ready_q) begin
            if (last_q) begin
              state   <= IDLE;
              ready_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              beat_cnt  <= beat_cnt + 4'd1;
              word_addr <= next_addr;
              // A bubble never follows the last beat, so this branch only sees non-last beats.
              if (STALL_EVERY > 0 && stall_cnt == STALL_LAST) begin
                stall_cnt <= 16'd0;
                ready_q   <= 1'b0;
                last_q    <= 1'b0;
              end else begin
                stall_cnt <= stall_cnt + 16'd1;
                ready_q   <= 1'b1;
                last_q    <= (beat_cnt + 4'd1 == len_q);
              end
            end
          end else begin
            ready_q <= 1'b1;
            last_q  <= (beat_cnt == len_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder: wrapping bursts, strobes, bubbles,
// reset mid-burst and back-to-back requests, checked with immediate assertions.

module tb_cbus_mem_responder;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  creq_a, creq_b;
  cbus_resp_t cresp_a, cresp_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_buf [16];
  logic [31:0] rd_buf [16];
  int          first_lat;
  int          last_errs;
  int          pat_len;
  logic [31:0] ready_pat;

  always #5 clk = ~clk;

  cbus_mem_responder #(.ADDR_BITS(14), .INIT_LATENCY(2), .STALL_EVERY(0)) dut_a (
    .clk(clk), .reset(reset), .creq(creq_a), .cresp(cresp_a)
  );

  cbus_mem_responder #(.ADDR_BITS(14), .INIT_LATENCY(2), .STALL_EVERY(4)) dut_b (
    .clk(clk), .reset(reset), .creq(creq_b), .cresp(cresp_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic wr, input logic [31:0] addr,
                               input logic [3:0] len, input logic [3:0] strobe, input logic [31:0] data);
    cbus_req_t r;
    r.valid    = valid;
    r.is_write = wr;
    r.size     = 3'd2;
    r.addr     = addr;
    r.strobe   = strobe;
    r.data     = data;
    r.len      = mlen_t'(len);
    if (sel == 0) creq_a = r;
    else          creq_b = r;
  endtask

  task automatic set_wdata(input int sel, input logic [31:0] data);
    if (sel == 0) creq_a.data = data;
    else          creq_b.data = data;
  endtask

  task automatic drop_valid(input int sel);
    if (sel == 0) creq_a.valid = 1'b0;
    else          creq_b.valid = 1'b0;
  endtask

  function automatic cbus_resp_t get_resp(input int sel);
    return (sel == 0) ? cresp_a : cresp_b;
  endfunction

  // Runs one burst from a negedge; returns at the negedge of the idle cycle after it.
  task automatic run_burst(input int sel, input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] strobe, input int reset_at, input logic hold_valid);
    int k = 0;
    int cyc = 0;
    cbus_resp_t r;
    first_lat = -1;
    last_errs = 0;
    ready_pat = 32'h0;
    pat_len   = 0;
    applyStimulus(sel, 1'b1, wr, addr, len, strobe, wr_buf[0]);
    while (k <= int'(len) && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      r = get_resp(sel);
      if (first_lat >= 0 || r.ready) begin
        ready_pat = {ready_pat[30:0], r.ready};
        pat_len++;
      end
      if (r.ready) begin
        if (first_lat < 0) first_lat = cyc;
        rd_buf[k] = r.data;
        if (r.last !== (k == int'(len))) last_errs++;
        if (wr) set_wdata(sel, wr_buf[k]);
        if (k == reset_at) begin
          reset = 1'b1;
          @(posedge clk);
          @(negedge clk);
          reset = 1'b0;
          drop_valid(sel);
          r = get_resp(sel);
          checkOutput("reset_ready", 32'(r.ready), 32'h0);
          checkOutput("reset_last", 32'(r.last), 32'h0);
          return;
        end
        k++;
      end else if (r.last) begin
        last_errs++;
      end
    end
    checkOutput("burst_done", 32'(k), 32'(int'(len) + 1));
    @(posedge clk);
    @(negedge clk);
    r = get_resp(sel);
    checkOutput("idle_ready", 32'(r.ready), 32'h0);
    if (!hold_valid) drop_valid(sel);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 4'd0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'd0, 4'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_a_ready", 32'(cresp_a.ready), 32'h0);
    checkOutput("rst_a_last", 32'(cresp_a.last), 32'h0);
    checkOutput("rst_a_data", cresp_a.data, 32'h0);
    checkOutput("rst_b_ready", 32'(cresp_b.ready), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] preload words 0..63 of dut_a");
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 16; k++) wr_buf[k] = 32'h1000 + 32'(blk * 16 + k);
      run_burst(0, 1'b1, 32'(blk * 64), 4'd15, 4'hF, -1, 1'b0);
    end

    $display("[TB] 16-beat wrapping read from 0x54");
    run_burst(0, 1'b0, 32'h54, 4'd15, 4'hF, -1, 1'b0);
    checkOutput("rd16_latency", 32'(first_lat), 32'd3);
    checkOutput("rd16_last", 32'(last_errs), 32'd0);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("rd16_beat%0d", k), rd_buf[k], 32'h1010 + 32'((5 + k) % 16));

    $display("[TB] single-beat strobed write to 0x8");
    wr_buf[0] = 32'h1122_3344;
    run_burst(0, 1'b1, 32'h8, 4'd0, 4'hF, -1, 1'b0);
    wr_buf[0] = 32'hAABB_CCDD;
    run_burst(0, 1'b1, 32'h8, 4'd0, 4'b0011, -1, 1'b0);
    checkOutput("wr1_latency", 32'(first_lat), 32'd3);
    checkOutput("wr1_ready_last", 32'(last_errs), 32'd0);
    run_burst(0, 1'b0, 32'h8, 4'd0, 4'hF, -1, 1'b0);
    checkOutput("rd1_data", rd_buf[0], 32'h1122_CCDD);
    checkOutput("rd1_ready_last", 32'(last_errs), 32'd0);

    $display("[TB] 16-beat wrapping write from 0x7C");
    for (int k = 0; k < 16; k++) wr_buf[k] = 32'(k);
    run_burst(0, 1'b1, 32'h7C, 4'd15, 4'hF, -1, 1'b0);
    run_burst(0, 1'b0, 32'h40, 4'd15, 4'hF, -1, 1'b0);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("wrap_word%0d", k), rd_buf[k], 32'((k + 1) % 16));
    run_burst(0, 1'b0, 32'h3C, 4'd0, 4'hF, -1, 1'b0);
    checkOutput("wrap_below", rd_buf[0], 32'h100F);
    run_burst(0, 1'b0, 32'h80, 4'd0, 4'hF, -1, 1'b0);
    checkOutput("wrap_above", rd_buf[0], 32'h1020);

    $display("[TB] bubbles every 4 beats on dut_b");
    for (int k = 0; k < 8; k++) wr_buf[k] = 32'h2000 + 32'(k);
    run_burst(1, 1'b1, 32'h0, 4'd7, 4'hF, -1, 1'b0);
    run_burst(1, 1'b0, 32'hC, 4'd7, 4'hF, -1, 1'b0);
    checkOutput("stall_pattern", ready_pat, 32'h1EF);
    checkOutput("stall_cycles", 32'(pat_len), 32'd9);
    checkOutput("stall_last", 32'(last_errs), 32'd0);
    checkOutput("stall_latency", 32'(first_lat), 32'd3);
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("stall_beat%0d", k), rd_buf[k], 32'h2000 + 32'((3 + k) % 8));

    $display("[TB] reset during beat 7 of a 16-beat write");
    for (int k = 0; k < 16; k++) wr_buf[k] = 32'hC0DE_0000 + 32'(k);
    run_burst(0, 1'b1, 32'h80, 4'd15, 4'hF, 7, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_idle", 32'(cresp_a.ready), 32'h0);
    run_burst(0, 1'b0, 32'h80, 4'd15, 4'hF, -1, 1'b0);
    checkOutput("post_reset_latency", 32'(first_lat), 32'd3);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("abort_word%0d", k), rd_buf[k],
                  (k < 7) ? 32'hC0DE_0000 + 32'(k) : 32'h1020 + 32'(k));

    $display("[TB] back-to-back reads");
    run_burst(0, 1'b0, 32'h0, 4'd3, 4'hF, -1, 1'b1);
    checkOutput("b2b_first0", rd_buf[0], 32'h1000);
    checkOutput("b2b_first1", rd_buf[1], 32'h1001);
    checkOutput("b2b_first2", rd_buf[2], 32'h1122_CCDD);
    checkOutput("b2b_first3", rd_buf[3], 32'h1003);
    run_burst(0, 1'b0, 32'h50, 4'd3, 4'hF, -1, 1'b0);
    checkOutput("b2b_latency", 32'(first_lat), 32'd3);
    checkOutput("b2b_last", 32'(last_errs), 32'd0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("b2b_second%0d", k), rd_buf[k], 32'(5 + k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Responder (slave) end of the cache bus (cbus_req_t / cbus_resp_t), serving the burst reads and writes that the I/D caches issue on refill and writeback.
- Backed by an internal word-addressed byte-strobed memory, with programmable first-beat latency and optional inter-beat bubbles.
- Used as the memory model in cache unit benches and as the on-chip scratch memory behind the cache arbiter.

Parameters:
- ADDR_BITS, 14, byte-address bits decoded; memory holds 2^(ADDR_BITS-2) 32-bit words; higher address bits are ignored (aliasing).
- INIT_LATENCY, 2, cycles from request acceptance to the first ready beat; minimum 1.
- STALL_EVERY, 0, insert one non-ready bubble after every STALL_EVERY beats; 0 = no bubbles.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- creq  in  cbus_req_t  fields: valid 1, is_write 1, size 3 (msize_t), addr 32, strobe 4, data 32, len 4 (mlen_t, beats = len+1: MLEN1=0 … MLEN16=15).
- cresp  out  cbus_resp_t  fields: ready 1, last 1, data 32.

Behaviour:
- Reset: state=IDLE; cresp.ready=0, cresp.last=0, cresp.data=0; beat and latency counters cleared. Memory contents are not cleared. Reset mid-burst aborts the burst immediately; no further beats are issued.
- States:
  - IDLE: if creq.valid, latch addr[ADDR_BITS-1:2], len, is_write; load the latency counter with INIT_LATENCY-1; go to WAIT.
  - WAIT: decrement the counter; at 0 go to BURST.
  - BURST: issue beats.
  - Requests are accepted only in IDLE. creq.valid in the cycle where last=1 is never re-accepted.
- Initiator contract: holds valid and addr/len/is_write stable from assertion until the last beat; may change data/strobe per beat.
- Beat: one cycle in BURST with cresp.ready=1. beat_cnt counts 0..len. cresp.last=1 exactly when ready=1 and beat_cnt==len. On the last beat, next state is IDLE.
- Beat address is a wrapping burst over an aligned block of (len+1) words. Word index = {base[high bits], (start_off + beat_cnt) mod (len+1)}, where the block boundary is aligned to len+1 (len+1 is always a power of two). For example, a 16-beat read starting at word offset 5 returns offsets 5..15, then 0..4.
- Read beat: cresp.data = mem[beat word address], combinational from the registered beat address, valid while ready=1. size is ignored and the full word is returned. Outside beats, data=0.
- Write beat: at the clock edge with ready=1, each byte lane i with creq.strobe[i]=1 is written from creq.data. Lanes with strobe=0 are unchanged. cresp.data=0.
- Bubbles: with STALL_EVERY=N>0, after every N-th beat that is not last, one cycle with ready=0 is inserted. beat_cnt and address hold during the bubble.
- Abort: if creq.valid=0 in WAIT or BURST, return to IDLE next cycle with ready=0. No write is performed in that cycle.
- Latency: a single-beat request accepted at cycle t gives ready=last=1 at cycle t+INIT_LATENCY+1. Minimum turnaround between consecutive transactions: 1 idle cycle (the IDLE accept cycle).
- Read-after-write on the same address: a read beat issued any cycle after the write edge returns the new data.

Test Plan:
- Preload mem[i]=0x1000+i. Issue a read with addr=0x0000_0054 (block 1, offset 5), len=MLEN16. Required: 16 beats with data 0x1015..0x101F then 0x1010..0x1014; last only on the 16th beat; the first ready is INIT_LATENCY+1 cycles after valid rises.
- Single-beat write: addr=0x8, data=0xAABBCCDD, strobe=4'b0011, over mem[2]=0x11223344. Then read back. Required: 0x1122CCDD; ready=last=1 on the same cycle.
- 16-beat wrap write: addr=0x40+0x3C, data=beat index. Then a 16-beat read from 0x40. Required: word k returns (k+1) mod 16 (the write started at offset 15, so offset 15 holds 0 and offset 0 holds 1); no other words modified.
- STALL_EVERY=4, 8-beat read. Required: ready pattern 1111 0 1111 over 9 cycles; last on the final cycle; data sequence unaffected by the bubble.
- Assert reset during beat 7 of a 16-beat write. Required: the next cycle has ready=0, last=0, state=IDLE; words written at beats 0..6 persist; words for beats 7..15 are unchanged. A fresh request after reset completes normally.
- Back-to-back: a second read with valid rising in the cycle after last. Required: no double-accept while the first last is asserted; the second transaction's first beat arrives INIT_LATENCY+1 cycles after its valid rises, with correct data.
